round_countdown_timer: RTL and testbench
========================================

Name: round_countdown_timer

Overview:
Game-round countdown timer for the guessing game. It sits directly downstream of the slow clock generator and consumes two of its toggle outputs: the 1 s toggle drives the countdown and the 400 Hz toggle drives the digit scan. It holds a two-digit BCD seconds count, reports win/timeout status to the game FSM, and presents one multiplexed digit at a time to the seven-segment decoder.

Parameters:
START_SECS, 30, round length in seconds; legal range 1..99, other values unsupported.

Ports:
clk  in  1  system clock (100 MHz)
resetSW  in  1  synchronous, active-high reset
sec_sig  in  1  square wave toggling once per second (same clk domain); every edge is one second
scan_sig  in  1  square wave toggling at 400 Hz cadence (same clk domain); every edge advances the digit scan
start  in  1  one-cycle pulse, already debounced; load START_SECS and run
pause  in  1  level; high freezes the countdown
guess_ok  in  1  one-cycle pulse; correct guess ends the round
secs_tens  out  4  BCD tens of remaining seconds
secs_ones  out  4  BCD ones of remaining seconds
an  out  2  digit enables, active-low; 2'b10 = ones digit, 2'b01 = tens digit
seg_bcd  out  4  value for the enabled digit; 4'hF means blank
running  out  1  high in RUN only
win  out  1  high in WIN
timeout  out  1  high in TIMEOUT
timeout_pulse  out  1  single-cycle pulse on entry to TIMEOUT

Behaviour:
- Everything updates on posedge clk. Reset is synchronous, active-high, and wins over all other inputs.
- Reset values:
  - state = IDLE.
  - secs_tens/secs_ones = BCD of START_SECS.
  - running = win = timeout = timeout_pulse = 0.
  - an = 2'b10; seg_bcd = ones digit of START_SECS.
  - Edge-detect registers sec_q and scan_q = 0; digit index = 0.
- Edge detect: sec_tick = sec_sig ^ sec_q, and sec_q <= sec_sig every cycle. scan_tick is formed the same way from scan_sig and scan_q. Both edges count, so each tick is a one-cycle pulse.
- States:
  - IDLE: start -> load START_SECS, go to RUN.
  - RUN:
    - start -> reload, stay in RUN.
    - guess_ok -> WIN.
    - pause=1 -> PAUSED, and a tick in that same cycle is ignored.
    - sec_tick -> decrement. If the count was 01, it becomes 00 and the state goes to TIMEOUT with timeout_pulse=1 for exactly one cycle.
  - PAUSED:
    - Ticks are ignored.
    - start -> reload, go to RUN.
    - guess_ok -> WIN.
    - pause=0 -> RUN; the next sec_tick decrements.
  - WIN: count frozen at its last value; start -> reload, go to RUN.
  - TIMEOUT: count held at 00; start -> reload, go to RUN.
- Priority within a cycle: resetSW > start > guess_ok > pause > sec_tick. guess_ok arriving in the same cycle as the final tick gives WIN, with the count left at 01 and no timeout_pulse.
- Decrement rule:
  - ones > 0: ones - 1.
  - ones = 0: ones = 9, tens - 1.
  - The count never wraps below 00.
- Count latency: the count changes in the cycle after the sec_sig edge is sampled (sec_sig edge seen at cycle n -> new count visible at n+1).
- Status outputs running, win and timeout are registered, decoded from state, and mutually exclusive.
- Scan:
  - scan_tick toggles the digit index in every state.
  - Index 0: an = 2'b10, seg_bcd = secs_ones.
  - Index 1: an = 2'b01, seg_bcd = secs_tens, or 4'hF when secs_tens = 0 (leading-zero blank).
  - an and seg_bcd are registered and reflect the count in the same cycle as secs_* updates.
- start in the cycle after reset is honoured normally.

Test Plan:
- START_SECS=3. Reset, pulse start, apply 3 sec_sig edges 10 cycles apart -> count 3,2,1,0; timeout_pulse high for 1 cycle only; timeout=1; running=0; count stays at 00 after 5 more edges.
- START_SECS=12. Start, then 3 sec edges -> count 09 (tens 0, ones 9). Tens scan phase shows seg_bcd=4'hF with an=2'b01; ones phase shows seg_bcd=9 with an=2'b10.
- START_SECS=30. Start, 2 edges (28), pause high, 4 edges -> still 28, running=0. Pause low, 1 edge -> 27, running=1.
- START_SECS=3. At count 01, guess_ok in the same cycle as the final sec edge -> win=1, count 01, timeout_pulse never asserts. Then start -> count 03, running=1, win=0.
- Reset: resetSW mid-RUN at count 17 (START_SECS=30) -> next cycle IDLE, count 30, all status outputs 0, an=2'b10, seg_bcd=0. start and resetSW asserted together -> reset wins.
- Scan alternation: 4 scan_sig edges with count 25 -> (an, seg_bcd) sequence alternates (01,2), (10,5), (01,2), (10,5), each update exactly one cycle after the edge.

Source files
------------

// File: rtl/round_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : round_countdown_timer
// Description : Two-digit BCD round countdown with win/timeout status and a
//               two-digit multiplexed display scan for the segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module round_countdown_timer #(
    parameter int START_SECS = 30
) (
    input  logic       clk,
    input  logic       resetSW,
    input  logic       sec_sig,
    input  logic       scan_sig,
    input  logic       start,
    input  logic       pause,
    input  logic       guess_ok,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic [1:0] an,
    output logic [3:0] seg_bcd,
    output logic       running,
    output logic       win,
    output logic       timeout,
    output logic       timeout_pulse
);

    localparam logic [3:0] c_START_TENS = 4'(START_SECS / 10);
    localparam logic [3:0] c_START_ONES = 4'(START_SECS % 10);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RUN     = 3'd1;
    localparam logic [2:0] c_ST_PAUSED  = 3'd2;
    localparam logic [2:0] c_ST_WIN     = 3'd3;
    localparam logic [2:0] c_ST_TIMEOUT = 3'd4;

    logic [2:0] r_state, w_state_nxt;
    logic [3:0] r_tens, r_ones, w_tens_nxt, w_ones_nxt;
    logic       r_sec_q, r_scan_q, r_idx, w_idx_nxt;
    logic       w_sec_tick, w_scan_tick, w_tpulse_nxt;
    logic [1:0] r_an, w_an_nxt;
    logic [3:0] r_seg, w_seg_nxt;
    logic       r_running, r_win, r_timeout, r_tpulse;

    assign w_sec_tick  = sec_sig ^ r_sec_q;
    assign w_scan_tick = scan_sig ^ r_scan_q;

    // start reloads from any state; the case only handles the rest
    always_comb begin
        w_state_nxt  = r_state;
        w_tens_nxt   = r_tens;
        w_ones_nxt   = r_ones;
        w_tpulse_nxt = 1'b0;
        if (start) begin
            w_tens_nxt  = c_START_TENS;
            w_ones_nxt  = c_START_ONES;
            w_state_nxt = c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (guess_ok) begin
                        w_state_nxt = c_ST_WIN;
                    end else if (pause) begin
                        w_state_nxt = c_ST_PAUSED;
                    end else if (w_sec_tick && (r_tens != 4'd0 || r_ones != 4'd0)) begin
                        if (r_ones != 4'd0) begin
                            w_ones_nxt = r_ones - 4'd1;
                        end else begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = r_tens - 4'd1;
                        end
                        if (r_tens == 4'd0 && r_ones == 4'd1) begin
                            w_state_nxt  = c_ST_TIMEOUT;
                            w_tpulse_nxt = 1'b1;
                        end
                    end
                end
                c_ST_PAUSED: begin
                    if (guess_ok) begin
                        w_state_nxt = c_ST_WIN;
                    end else if (!pause) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Display is built from next-state count so it tracks secs_* with no lag
    always_comb begin
        w_idx_nxt = r_idx ^ w_scan_tick;
        w_an_nxt  = w_idx_nxt ? 2'b01 : 2'b10;
        if (w_idx_nxt) begin
            w_seg_nxt = (w_tens_nxt == 4'd0) ? 4'hF : w_tens_nxt;
        end else begin
            w_seg_nxt = w_ones_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (resetSW) begin
            r_state   <= c_ST_IDLE;
            r_tens    <= c_START_TENS;
            r_ones    <= c_START_ONES;
            r_sec_q   <= 1'b0;
            r_scan_q  <= 1'b0;
            r_idx     <= 1'b0;
            r_an      <= 2'b10;
            r_seg     <= c_START_ONES;
            r_running <= 1'b0;
            r_win     <= 1'b0;
            r_timeout <= 1'b0;
            r_tpulse  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_sec_q   <= sec_sig;
            r_scan_q  <= scan_sig;
            r_idx     <= w_idx_nxt;
            r_an      <= w_an_nxt;
            r_seg     <= w_seg_nxt;
            r_running <= (w_state_nxt == c_ST_RUN);
            r_win     <= (w_state_nxt == c_ST_WIN);
            r_timeout <= (w_state_nxt == c_ST_TIMEOUT);
            r_tpulse  <= w_tpulse_nxt;
        end
    end

    assign secs_tens     = r_tens;
    assign secs_ones     = r_ones;
    assign an            = r_an;
    assign seg_bcd       = r_seg;
    assign running       = r_running;
    assign win           = r_win;
    assign timeout       = r_timeout;
    assign timeout_pulse = r_tpulse;

endmodule
`default_nettype wire

// File: tb/tb_round_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_countdown_timer
// Description : Randomized scoreboard bench for round_countdown_timer against
//               an integer-seconds reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_countdown_timer;

    localparam int START_SECS = 12;
    localparam int NCYC       = 6000;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_WIN     = 3;
    localparam int M_TIMEOUT = 4;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] an;
        logic [3:0] seg;
        logic       run;
        logic       win;
        logic       to;
        logic       tp;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetSW = 1'b1;
    logic       sec_sig = 1'b0;
    logic       scan_sig = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       guess_ok = 1'b0;
    logic [3:0] secs_tens, secs_ones, seg_bcd;
    logic [1:0] an;
    logic       running, win, timeout, timeout_pulse;

    round_countdown_timer #(.START_SECS(START_SECS)) dut (
        .clk(clk), .resetSW(resetSW), .sec_sig(sec_sig), .scan_sig(scan_sig),
        .start(start), .pause(pause), .guess_ok(guess_ok),
        .secs_tens(secs_tens), .secs_ones(secs_ones), .an(an), .seg_bcd(seg_bcd),
        .running(running), .win(win), .timeout(timeout), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_timeouts = 0;
    int   n_wins = 0;

    // Reference model: remaining time as a plain integer
    int   m_state = M_IDLE;
    int   m_secs  = START_SECS;
    bit   m_idx   = 1'b0;
    bit   m_secq  = 1'b0;
    bit   m_scanq = 1'b0;
    bit   m_tp    = 1'b0;

    task automatic model_step();
        bit tick, stick;
        if (resetSW) begin
            m_state = M_IDLE; m_secs = START_SECS; m_idx = 0;
            m_secq = 0; m_scanq = 0; m_tp = 0;
        end else begin
            tick  = (sec_sig != m_secq);
            stick = (scan_sig != m_scanq);
            m_secq = sec_sig; m_scanq = scan_sig; m_tp = 0;
            if (start) begin
                m_secs = START_SECS; m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                if (guess_ok) begin
                    m_state = M_WIN; n_wins++;
                end else if (pause) begin
                    m_state = M_PAUSED;
                end else if (tick && m_secs > 0) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_state = M_TIMEOUT; m_tp = 1; n_timeouts++;
                    end
                end
            end else if (m_state == M_PAUSED) begin
                if (guess_ok) begin
                    m_state = M_WIN; n_wins++;
                end else if (!pause) begin
                    m_state = M_RUN;
                end
            end
            if (stick) m_idx = ~m_idx;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   t, o;
        t = m_secs / 10;
        o = m_secs % 10;
        e.tens = 4'(t);
        e.ones = 4'(o);
        e.an   = m_idx ? 2'b01 : 2'b10;
        e.seg  = m_idx ? ((t == 0) ? 4'hF : 4'(t)) : 4'(o);
        e.run  = (m_state == M_RUN);
        e.win  = (m_state == M_WIN);
        e.to   = (m_state == M_TIMEOUT);
        e.tp   = m_tp;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Stimulus: drive on negedge, predict post-edge outputs, enqueue
    initial begin
        bit pend;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            resetSW = (c < 2) || ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 79) == 0)
                   || (m_state == M_IDLE && $urandom_range(0, 3) == 0)
                   || ((m_state == M_WIN || m_state == M_TIMEOUT) && $urandom_range(0, 19) == 0);
            if (resetSW) start = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            if ($urandom_range(0, 2) == 0) sec_sig = ~sec_sig;
            if ($urandom_range(0, 2) == 0) scan_sig = ~scan_sig;
            pend = (sec_sig != m_secq);
            guess_ok = ($urandom_range(0, 199) == 0)
                    || (m_state == M_RUN && m_secs == 1 && pend && !pause
                        && $urandom_range(0, 1) == 0);
            model_step();
            q.push_back(model_out());
        end
        @(negedge clk);
        resetSW = 0; start = 0; guess_ok = 0;
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        if (n_timeouts == 0 || n_wins == 0)
            $display("note: timeouts=%0d wins=%0d", n_timeouts, n_wins);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: one DUT output set per cycle, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count",  {24'd0, secs_tens, secs_ones}, {24'd0, e.tens, e.ones});
                chk("scan",   {26'd0, an, seg_bcd},          {26'd0, e.an, e.seg});
                chk("status", {28'd0, running, win, timeout, timeout_pulse},
                              {28'd0, e.run, e.win, e.to, e.tp});
            end
        end
    end

endmodule
`default_nettype wire
